// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction encoder/loader: opcodes, request kinds, NOP and FSM states.
// Optional checksum output of instr_enc_loader is enabled with ENC_LOADER_CHECKSUM_EN.
package ctrl_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] KIND_R    = 3'd0;
    localparam logic [2:0] KIND_IALU = 3'd1;
    localparam logic [2:0] KIND_LW   = 3'd2;
    localparam logic [2:0] KIND_SW   = 3'd3;
    localparam logic [2:0] KIND_BEQ  = 3'd4;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush
    } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: request kind and fields in, 32-bit word and illegal flag out.
module instr_pack
    import ctrl_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (kind)
            KIND_R:    word = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
            KIND_IALU: word = {imm[11:0], rs1, funct3, rd, OP_IALU};
            KIND_LW:   word = {imm[11:0], rs1, 3'b010, rd, OP_LOAD};
            KIND_SW:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
            KIND_BEQ: begin
                // Branch offsets are halfword aligned; an odd offset cannot be encoded.
                if (imm[0]) begin
                    illegal = 1'b1;
                end else begin
                    word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
                end
            end
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_enc_loader.sv
// Loads a session of encoded RV32I words into imem at consecutive addresses.
// Define ENC_LOADER_CHECKSUM_EN to add the csum output (XOR of words written this session).
module instr_enc_loader
    import ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef ENC_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       csum
`endif
);

    localparam logic [ADDR_W-1:0] BaseAddr = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   RemOne   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   rem_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [31:0]       word;
    logic              illegal;
    logic              accept;
    logic              start_ok;

    instr_pack u_pack (
        .kind    (kind),
        .rd      (rd),
        .rs1     (rs1),
        .rs2     (rs2),
        .funct3  (funct3),
        .funct7  (funct7),
        .imm     (imm),
        .word    (word),
        .illegal (illegal)
    );

    assign accept   = in_valid & in_ready;
    assign start_ok = (state_q == StIdle) & start;
    assign busy     = (state_q != StIdle);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (len == '0) ? StFlush : StLoad;
                end
            end
            StLoad: begin
                in_ready = (rem_q != '0);
                if (in_valid && in_ready && rem_q == RemOne) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // With len>0 this cycle carries the final write, registered on the accept edge.
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_en   <= accept;
            if (start_ok) begin
                err   <= 1'b0;
                rem_q <= len;
                cnt_q <= BaseAddr;
            end
            if (accept) begin
                wr_data <= word;
                wr_addr <= cnt_q;
                cnt_q   <= cnt_q + 1'b1;
                rem_q   <= rem_q - RemOne;
                if (illegal) begin
                    err <= 1'b1;
                end
            end
        end
    end

`ifdef ENC_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ word;
        end
    end
`endif

endmodule

// File: tb/tb_instr_enc_loader.sv
// Directed bench for instr_enc_loader: vector table for encodings plus hand sequences for sessions.
module tb_instr_enc_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  len;
    logic        in_valid;
    logic [2:0]  kind;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [12:0] imm;

    logic        in_ready, wr_en, busy, done, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    logic        w_in_ready, w_wr_en, w_busy, w_done, w_err;
    logic [3:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [4:0]  w_len;

    assign w_len = len[4:0];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    instr_enc_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .kind     (kind),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    instr_enc_loader #(.ADDR_W(4), .BASE_ADDR(14)) dut_wrap (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (w_len),
        .in_valid (in_valid),
        .in_ready (w_in_ready),
        .kind     (kind),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .wr_en    (w_wr_en),
        .wr_addr  (w_wr_addr),
        .wr_data  (w_wr_data),
        .busy     (w_busy),
        .done     (w_done),
        .err      (w_err)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [12:0] imm;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        kind   = v.kind;
        rd     = v.rd;
        rs1    = v.rs1;
        rs2    = v.rs2;
        funct3 = v.funct3;
        funct7 = v.funct7;
        imm    = v.imm;
    endtask

    task automatic do_start(input logic [8:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    initial begin
        // Fields that an encoding ignores are set to non-zero junk.
        vecs[0] = '{3'd1, 5'd1, 5'd0, 5'd9,  3'd0, 7'h7f, 13'h0005, 32'h0050_0093}; // addi x1,x0,5
        vecs[1] = '{3'd0, 5'd3, 5'd1, 5'd2,  3'd0, 7'h00, 13'h1abc, 32'h0020_81B3}; // add x3,x1,x2
        vecs[2] = '{3'd2, 5'd2, 5'd1, 5'd7,  3'd7, 7'h55, 13'h0008, 32'h0080_A103}; // lw x2,8(x1)
        vecs[3] = '{3'd3, 5'd31, 5'd1, 5'd2, 3'd7, 7'h55, 13'h0004, 32'h0020_A223}; // sw x2,4(x1)
        vecs[4] = '{3'd4, 5'd31, 5'd1, 5'd2, 3'd7, 7'h55, 13'h1FF8, 32'hFE20_8CE3}; // beq x1,x2,-8
        vecs[5] = '{3'd6, 5'd1, 5'd1, 5'd1,  3'd1, 7'h01, 13'h0001, 32'h0000_0013}; // illegal kind
        vecs[6] = '{3'd4, 5'd0, 5'd1, 5'd2,  3'd0, 7'h00, 13'h0003, 32'h0000_0013}; // odd BEQ offset

        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        drive(vecs[0]);
        step(); step();
        reset = 1'b0;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Encoding session, in_valid held high.
        do_start(9'd5);
        check("s1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            check($sformatf("s1_ready_%0d", i), 32'(in_ready), 32'd1);
            step();
            check($sformatf("s1_wr_en_%0d", i), 32'(wr_en), 32'd1);
            check($sformatf("s1_data_%0d", i), wr_data, vecs[i].word);
            check($sformatf("s1_addr_%0d", i), 32'(wr_addr), 32'(i));
            check($sformatf("s1_done_%0d", i), 32'(done), (i == 4) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        check("s1_ready_end", 32'(in_ready), 32'd0);
        check("s1_err", 32'(err), 32'd0);
        step();
        check("s1_idle_busy", 32'(busy), 32'd0);
        check("s1_idle_done", 32'(done), 32'd0);
        check("s1_idle_wr_en", 32'(wr_en), 32'd0);
        check("s1_hold_data", wr_data, 32'hFE20_8CE3);

        // Back-pressure with a start pulse during LOAD.
        do_start(9'd2);
        drive(vecs[0]); in_valid = 1'b1;
        step();
        check("bp_wr_en_a", 32'(wr_en), 32'd1);
        check("bp_addr_a", 32'(wr_addr), 32'd0);
        check("bp_data_a", wr_data, vecs[0].word);
        in_valid = 1'b0; start = 1'b1; len = 9'd7;
        step();
        start = 1'b0;
        check("bp_gap1_wr_en", 32'(wr_en), 32'd0);
        check("bp_gap1_ready", 32'(in_ready), 32'd1);
        step();
        check("bp_gap2_wr_en", 32'(wr_en), 32'd0);
        check("bp_gap2_busy", 32'(busy), 32'd1);
        drive(vecs[1]); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("bp_wr_en_b", 32'(wr_en), 32'd1);
        check("bp_addr_b", 32'(wr_addr), 32'd1);
        check("bp_data_b", wr_data, vecs[1].word);
        check("bp_done", 32'(done), 32'd1);
        check("bp_ready_after", 32'(in_ready), 32'd0);
        step();
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_wr_en", 32'(wr_en), 32'd0);

        // len=0 session.
        do_start(9'd0);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd1);
        check("z_wr_en", 32'(wr_en), 32'd0);
        step();
        check("z_done_after", 32'(done), 32'd0);
        check("z_busy_after", 32'(busy), 32'd0);

        // Illegal requests still write NOP, advance and count down.
        do_start(9'd2);
        drive(vecs[5]); in_valid = 1'b1;
        step();
        check("il_kind_data", wr_data, vecs[5].word);
        check("il_kind_addr", 32'(wr_addr), 32'd0);
        check("il_kind_err", 32'(err), 32'd1);
        drive(vecs[6]);
        step();
        in_valid = 1'b0;
        check("il_beq_data", wr_data, vecs[6].word);
        check("il_beq_addr", 32'(wr_addr), 32'd1);
        check("il_beq_done", 32'(done), 32'd1);
        step();
        check("il_err_sticky", 32'(err), 32'd1);
        do_start(9'd1);
        check("il_err_cleared", 32'(err), 32'd0);
        drive(vecs[0]); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("il_next_done", 32'(done), 32'd1);
        check("il_next_err", 32'(err), 32'd0);
        step();

        // Address wrap on the 4-bit instance starting at 14.
        do_start(9'd4);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("wrap_wr_en_%0d", i), 32'(w_wr_en), 32'd1);
            check($sformatf("wrap_addr_%0d", i), 32'(w_wr_addr), 32'((14 + i) % 16));
        end
        in_valid = 1'b0;
        check("wrap_done", 32'(w_done), 32'd1);
        step();

        // Reset mid-session.
        do_start(9'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(vecs[i]);
            step();
            check($sformatf("mr_addr_%0d", i), 32'(wr_addr), 32'(i));
        end
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        check("mr_wr_en", 32'(wr_en), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        step();
        check("mr_done_later", 32'(done), 32'd0);
        do_start(9'd1);
        drive(vecs[2]); in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mr_restart_addr", 32'(wr_addr), 32'd0);
        check("mr_restart_data", wr_data, vecs[2].word);
        check("mr_restart_done", 32'(done), 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
